// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC_512 accumulation stage.
package mac_pkg;

  localparam int MAC_IN_W      = 8;
  localparam int MAC_ACC_W     = 20;
  localparam int MAC_MAX_TERMS = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } mac_state_t;

  // Counter must be able to hold MAX_TERMS itself, hence one bit above log2.
  function automatic int mac_cnt_w(input int max_terms);
    return $clog2(max_terms) + 1;
  endfunction

endpackage

// File: rtl/cla_acc_adder.sv
// W-bit adder built as a ripple of 4-bit carry-lookahead slices.
// W must be a multiple of 4.
module cla_acc_adder #(
  parameter int W = 20
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Ci,
  output logic [W-1:0] S,
  output logic         Cout
);

  localparam int SLICES = W / 4;

  logic [SLICES:0] slice_c;

  assign slice_c[0] = Ci;

  // Each slice resolves its internal carries from generate/propagate terms
  // and only the slice carry-out ripples to the next slice.
  for (genvar s = 0; s < SLICES; s++) begin : g_slice
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign a = A[4*s +: 4];
    assign b = B[4*s +: 4];
    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = slice_c[s];
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & c[0]);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & c[0]);

    assign S[4*s +: 4] = p ^ c[3:0];
    assign slice_c[s+1] = c[4];
  end

  assign Cout = slice_c[SLICES];

endmodule

// File: rtl/mac_accum_stage.sv
// Accumulates one group of unsigned terms into a wide register and holds the
// result for the output stage. A group ends on in_last or after MAX_TERMS.
module mac_accum_stage
  import mac_pkg::*;
#(
  parameter int IN_W      = MAC_IN_W,
  parameter int ACC_W     = MAC_ACC_W,
  parameter int MAX_TERMS = MAC_MAX_TERMS,
  parameter int CNT_W     = mac_cnt_w(MAX_TERMS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_overrun,
  output logic [CNT_W-1:0] term_cnt
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  mac_state_t       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             overrun_q, overrun_d;
  logic             run_q;

  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] sum;
  logic             carry;
  logic             in_fire;
  logic             out_fire;

  assign addend = ACC_W'(in_data);

  cla_acc_adder #(.W(ACC_W)) u_adder (
    .A    (acc_q),
    .B    (addend),
    .Ci   (1'b0),
    .S    (sum),
    .Cout (carry)
  );

  // run_q keeps in_ready low during reset and for the first edge after it,
  // without routing rst_n combinationally to the output.
  assign in_ready  = en && run_q && (state_q != HOLD);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready && en;

  assign out_valid   = (state_q == HOLD);
  assign out_data    = acc_q;
  assign out_ovf     = ovf_q;
  assign out_overrun = overrun_q;
  assign term_cnt    = cnt_q;

  // Next-state and datapath update; en is already folded into both fires.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (in_fire) begin
          acc_d     = addend;
          cnt_d     = ONE_CNT;
          ovf_d     = 1'b0;
          overrun_d = 1'b0;
          if (in_last) begin
            state_d = HOLD;
          end else if (ONE_CNT == MAX_CNT) begin
            state_d   = HOLD;
            overrun_d = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (in_fire) begin
          acc_d = sum;
          ovf_d = ovf_q | carry;
          cnt_d = cnt_q + ONE_CNT;
          if (in_last) begin
            state_d   = HOLD;
            overrun_d = 1'b0;
          end else if (cnt_d == MAX_CNT) begin
            state_d   = HOLD;
            overrun_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_fire) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset discards any partial or held group.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
      run_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      overrun_q <= overrun_d;
      run_q     <= 1'b1;
    end
  end

endmodule
